// File: rtl/reg_write_sched.sv
// reg_write_sched: round-robin scheduler that routes up to four register-write
// requests per cycle onto three registered GPR write ports and one PC port.
//
// Handshake: a requester's transfer happens when req_valid[i] and req_ready[i]
// are both high at posedge clk. req_ready is combinational from req_valid,
// req_addr, the round-robin pointer, stall and rst. Requesters hold their
// request stable until it completes, so nothing is buffered here.
module reg_write_sched #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [R-1:0]     req_valid,
  input  logic [4*R-1:0]   req_addr,
  input  logic [N*R-1:0]   req_data,
  output logic [R-1:0]     req_ready,
  output logic [3:0]       write_address_1,
  output logic [3:0]       write_address_2,
  output logic [3:0]       write_address_3,
  output logic [N-1:0]     write_data_1,
  output logic [N-1:0]     write_data_2,
  output logic [N-1:0]     write_data_3,
  output logic             write_enable_1,
  output logic             write_enable_2,
  output logic             write_enable_3,
  output logic [N-1:0]     pc_update,
  output logic             pc_write,
  output logic [15:0]      conflict_count
);

  localparam logic [3:0] PC_ADDR = 4'hF;

  logic [1:0]   ptr;
  logic [2:0]   g_en;
  logic [3:0]   g_addr [3];
  logic [N-1:0] g_data [3];
  logic         pc_grant;
  logic [N-1:0] pc_data_nxt;
  logic         any_grant;
  logic [1:0]   last_idx;
  logic [1:0]   gpr_cnt;
  logic [1:0]   idx;
  logic [3:0]   cur_addr;
  logic         dup;

  // Scan requesters from ptr onward, granting each one whose slot is still free.
  always_comb begin
    req_ready   = '0;
    g_en        = '0;
    for (int p = 0; p < 3; p++) begin
      g_addr[p] = '0;
      g_data[p] = '0;
    end
    pc_grant    = 1'b0;
    pc_data_nxt = '0;
    any_grant   = 1'b0;
    last_idx    = ptr;
    gpr_cnt     = 2'd0;
    idx         = 2'd0;
    cur_addr    = 4'd0;
    dup         = 1'b0;
    for (int k = 0; k < R; k++) begin
      idx      = ptr + 2'(k);
      cur_addr = req_addr[4*idx +: 4];
      if (req_valid[idx] && !stall && !rst) begin
        if (cur_addr == PC_ADDR) begin
          if (!pc_grant) begin
            pc_grant       = 1'b1;
            pc_data_nxt    = req_data[N*idx +: N];
            req_ready[idx] = 1'b1;
            any_grant      = 1'b1;
            last_idx       = idx;
          end
        end else begin
          // A second write to the same GPR in one cycle would be ambiguous.
          dup = 1'b0;
          for (int j = 0; j < 3; j++) begin
            if ((2'(j) < gpr_cnt) && (g_addr[j] == cur_addr)) dup = 1'b1;
          end
          if ((gpr_cnt != 2'd3) && !dup) begin
            g_en[gpr_cnt]   = 1'b1;
            g_addr[gpr_cnt] = cur_addr;
            g_data[gpr_cnt] = req_data[N*idx +: N];
            gpr_cnt         = gpr_cnt + 2'd1;
            req_ready[idx]  = 1'b1;
            any_grant       = 1'b1;
            last_idx        = idx;
          end
        end
      end
    end
  end

  // Register granted writes; idle ports drop enable but keep their last address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= 2'd0;
      write_enable_1  <= 1'b0;
      write_enable_2  <= 1'b0;
      write_enable_3  <= 1'b0;
      write_address_1 <= '0;
      write_address_2 <= '0;
      write_address_3 <= '0;
      write_data_1    <= '0;
      write_data_2    <= '0;
      write_data_3    <= '0;
      pc_write        <= 1'b0;
      pc_update       <= '0;
    end else begin
      write_enable_1 <= g_en[0];
      write_enable_2 <= g_en[1];
      write_enable_3 <= g_en[2];
      pc_write       <= pc_grant;
      if (g_en[0]) begin
        write_address_1 <= g_addr[0];
        write_data_1    <= g_data[0];
      end
      if (g_en[1]) begin
        write_address_2 <= g_addr[1];
        write_data_2    <= g_data[1];
      end
      if (g_en[2]) begin
        write_address_3 <= g_addr[2];
        write_data_3    <= g_data[2];
      end
      if (pc_grant) pc_update <= pc_data_nxt;
      // Next scan starts just past the last requester served.
      if (any_grant) ptr <= last_idx + 2'd1;
    end
  end

  // Count cycles where at least one valid requester was left waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count <= 16'd0;
    end else if ((|(req_valid & ~req_ready)) && (conflict_count != 16'hFFFF)) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_reg_write_sched.sv
// tb_reg_write_sched: directed scenarios for reg_write_sched. The driver checks
// req_ready each cycle and queues the expected registered outputs; a monitor
// pops and compares them one cycle after each handshake edge.
module tb_reg_write_sched;
  localparam int N = 32;
  localparam int R = 4;
  localparam int W = 4 + 12 + 4*N + 16;

  logic           clk;
  logic           rst;
  logic           stall;
  logic [R-1:0]   req_valid;
  logic [4*R-1:0] req_addr;
  logic [N*R-1:0] req_data;
  logic [R-1:0]   req_ready;
  logic [3:0]     write_address_1, write_address_2, write_address_3;
  logic [N-1:0]   write_data_1, write_data_2, write_data_3;
  logic           write_enable_1, write_enable_2, write_enable_3;
  logic [N-1:0]   pc_update;
  logic           pc_write;
  logic [15:0]    conflict_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];

  // expected output model state (hand-set per scenario)
  logic [2:0]   e_we;
  logic         e_pcw;
  logic [3:0]   e_wa [3];
  logic [N-1:0] e_wd [3];
  logic [N-1:0] e_pc;
  logic [15:0]  e_cc;

  reg_write_sched #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .write_address_1(write_address_1), .write_address_2(write_address_2),
    .write_address_3(write_address_3),
    .write_data_1(write_data_1), .write_data_2(write_data_2), .write_data_3(write_data_3),
    .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
    .write_enable_3(write_enable_3),
    .pc_update(pc_update), .pc_write(pc_write), .conflict_count(conflict_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack_exp();
    return {e_we, e_pcw, e_wa[0], e_wa[1], e_wa[2], e_wd[0], e_wd[1], e_wd[2], e_pc, e_cc};
  endfunction

  // monitor / scoreboard
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = {write_enable_3, write_enable_2, write_enable_1, pc_write,
               write_address_1, write_address_2, write_address_3,
               write_data_1, write_data_2, write_data_3, pc_update, conflict_count};
        n_cmp++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic req(input int i, input logic [3:0] a, input logic [N-1:0] d);
    req_valid[i]       = 1'b1;
    req_addr[4*i +: 4] = a;
    req_data[N*i +: N] = d;
  endtask

  task automatic exp_port(input int p, input logic [3:0] a, input logic [N-1:0] d);
    e_we[p-1] = 1'b1;
    e_wa[p-1] = a;
    e_wd[p-1] = d;
  endtask

  task automatic exp_pc(input logic [N-1:0] d);
    e_pcw = 1'b1;
    e_pc  = d;
  endtask

  task automatic exp_reset();
    e_we  = '0;
    e_pcw = 1'b0;
    e_pc  = '0;
    e_cc  = '0;
    for (int p = 0; p < 3; p++) begin
      e_wa[p] = '0;
      e_wd[p] = '0;
    end
  endtask

  // one cycle: apply rst/stall, check ready mid-cycle, queue expected outputs
  task automatic go(input string name, input logic r, input logic s, input logic [R-1:0] exp_ready);
    rst   = r;
    stall = s;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL ready_%s actual=%b required=%b", name, req_ready, exp_ready);
    end
    exp_q.push_back(pack_exp());
    e_we  = '0;
    e_pcw = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    clear_reqs();
    exp_reset();
    @(posedge clk);
    #2;

    // reset with everything valid: nothing may be granted
    req(0, 4'd1, 32'h100); req(1, 4'd2, 32'h101); req(2, 4'd3, 32'h102); req(3, 4'd4, 32'h103);
    exp_reset();
    go("rst0", 1'b1, 1'b0, 4'b0000);
    go("rst1", 1'b1, 1'b0, 4'b0000);

    // four GPR requests, ptr=0: req3 loses the fourth slot
    exp_port(1, 4'd1, 32'h100); exp_port(2, 4'd2, 32'h101); exp_port(3, 4'd3, 32'h102);
    e_cc = 16'd1;
    go("fill3", 1'b0, 1'b0, 4'b0111);

    // req3 alone at ptr=3; ports 2/3 keep their previous contents
    clear_reqs();
    req(3, 4'd4, 32'h103);
    exp_port(1, 4'd4, 32'h103);
    go("req3_first", 1'b0, 1'b0, 4'b1000);

    // same GPR address twice, ptr=0: only req0
    clear_reqs();
    req(0, 4'd5, 32'hAA); req(1, 4'd5, 32'hBB);
    exp_port(1, 4'd5, 32'hAA);
    e_cc = 16'd2;
    go("same_addr", 1'b0, 1'b0, 4'b0001);

    clear_reqs();
    req(1, 4'd5, 32'hBB);
    exp_port(1, 4'd5, 32'hBB);
    go("same_addr_next", 1'b0, 1'b0, 4'b0010);

    // ptr=2: lone req3 moves ptr back to 0
    clear_reqs();
    req(3, 4'd9, 32'h33);
    exp_port(1, 4'd9, 32'h33);
    go("wrap", 1'b0, 1'b0, 4'b1000);

    // two PC writes in one cycle: req0 wins, req2 waits, ptr -> 2
    clear_reqs();
    req(0, 4'd15, 32'hC0); req(1, 4'd7, 32'h70); req(2, 4'd15, 32'hC2);
    exp_pc(32'hC0);
    exp_port(1, 4'd7, 32'h70);
    e_cc = 16'd3;
    go("pc_conflict", 1'b0, 1'b0, 4'b0011);

    clear_reqs();
    req(2, 4'd15, 32'hC2);
    exp_pc(32'hC2);
    go("pc_second", 1'b0, 1'b0, 4'b0100);

    // stall three cycles with everything valid (ptr stays 3)
    clear_reqs();
    req(0, 4'd1, 32'h200); req(1, 4'd2, 32'h201); req(2, 4'd3, 32'h202); req(3, 4'd4, 32'h203);
    for (int i = 0; i < 3; i++) begin
      e_cc = e_cc + 16'd1;
      go("stall", 1'b0, 1'b1, 4'b0000);
    end

    // ptr=3 after stall: scan 3,0,1,2; req2 has no port left; ptr -> 2
    exp_port(1, 4'd4, 32'h203); exp_port(2, 4'd1, 32'h200); exp_port(3, 4'd2, 32'h201);
    e_cc = 16'd7;
    go("after_stall", 1'b0, 1'b0, 4'b1011);

    // ptr=2: scan 2,3,0,1 with a duplicate GPR and a duplicate PC; ptr -> 1
    clear_reqs();
    req(0, 4'd15, 32'hE0); req(1, 4'd15, 32'hE1); req(2, 4'd6, 32'hE2); req(3, 4'd6, 32'hE3);
    exp_port(1, 4'd6, 32'hE2);
    exp_pc(32'hE0);
    e_cc = 16'd8;
    go("mixed_dup", 1'b0, 1'b0, 4'b0101);

    // reset alongside a request that would be fully granted
    clear_reqs();
    req(0, 4'd1, 32'h11); req(1, 4'd2, 32'h22); req(2, 4'd3, 32'h33); req(3, 4'd15, 32'hFF);
    exp_reset();
    go("rst_mid", 1'b1, 1'b0, 4'b0000);

    // ptr back at 0: the same request is fully granted
    exp_port(1, 4'd1, 32'h11); exp_port(2, 4'd2, 32'h22); exp_port(3, 4'd3, 32'h33);
    exp_pc(32'hFF);
    go("full_grant", 1'b0, 1'b0, 4'b1111);

    // long stall with one waiter drives the counter into saturation
    clear_reqs();
    req(0, 4'd8, 32'h88);
    for (int i = 0; i < 65538; i++) begin
      e_cc = (e_cc == 16'hFFFF) ? e_cc : e_cc + 16'd1;
      go("sat", 1'b0, 1'b1, 4'b0000);
    end

    // nobody waiting: counter stays saturated
    clear_reqs();
    go("idle", 1'b0, 1'b0, 4'b0000);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
